// File: rtl/mul_input_arbiter_if.sv
// Packet bus between the two requesters (NoC data path, config loader) and the
// multiplier input. The slave modport is the arbiter's view of the bus.
interface mul_input_arbiter_if #(
    parameter int NETWORK_SIZE  = 256,
    parameter int PAYLOAD_WIDTH = 32,
    parameter int TYPE_WIDTH    = 3
);
    // Integer floor square root so the sequence width stays a pure integer expression.
    function automatic int isqrt(input int n);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= n) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int SOURCE_WIDTH = $clog2(NETWORK_SIZE);
    localparam int SEQ_WIDTH    = $clog2(isqrt(NETWORK_SIZE) * 2);
    localparam int DATA_WIDTH   = PAYLOAD_WIDTH + SOURCE_WIDTH;

    logic                  dat_valid;
    logic [TYPE_WIDTH-1:0] dat_type;
    logic [SEQ_WIDTH-1:0]  dat_seqNum;
    logic [DATA_WIDTH-1:0] dat_data;
    logic                  dat_halt;

    logic                  cfg_valid;
    logic [TYPE_WIDTH-1:0] cfg_type;
    logic [SEQ_WIDTH-1:0]  cfg_seqNum;
    logic [DATA_WIDTH-1:0] cfg_data;
    logic                  cfg_last;
    logic                  cfg_halt;

    logic                  MUL_halt;
    logic                  MUL_valid;
    logic [TYPE_WIDTH-1:0] MUL_type;
    logic [SEQ_WIDTH-1:0]  MUL_seqNum;
    logic [DATA_WIDTH-1:0] MUL_data;

    logic                  cfg_busy;
    logic                  cfg_err;

    modport slave (
        input  dat_valid, dat_type, dat_seqNum, dat_data,
        output dat_halt,
        input  cfg_valid, cfg_type, cfg_seqNum, cfg_data, cfg_last,
        output cfg_halt,
        input  MUL_halt,
        output MUL_valid, MUL_type, MUL_seqNum, MUL_data,
        output cfg_busy, cfg_err
    );

    modport master (
        output dat_valid, dat_type, dat_seqNum, dat_data,
        input  dat_halt,
        output cfg_valid, cfg_type, cfg_seqNum, cfg_data, cfg_last,
        input  cfg_halt,
        output MUL_halt,
        input  MUL_valid, MUL_type, MUL_seqNum, MUL_data,
        input  cfg_busy, cfg_err
    );
endinterface

// File: rtl/mul_input_arbiter.sv
// Round-robin arbiter sharing the multiplier packet input between the data path
// and the config loader; config bursts lock the grant until their last beat.
module mul_input_arbiter #(
    parameter int NETWORK_SIZE  = 256,
    parameter int PAYLOAD_WIDTH = 32,
    parameter int TYPE_WIDTH    = 3
) (
    input  logic                clk,
    input  logic                rst,
    mul_input_arbiter_if.slave  bus
);
    function automatic int isqrt(input int n);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= n) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int SOURCE_WIDTH = $clog2(NETWORK_SIZE);
    localparam int SEQ_WIDTH    = $clog2(isqrt(NETWORK_SIZE) * 2);
    localparam int DATA_WIDTH   = PAYLOAD_WIDTH + SOURCE_WIDTH;

    localparam logic [TYPE_WIDTH-1:0] TYPE_DATA = {TYPE_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_CFG_LOCK = 1'b1
    } state_e;

    typedef enum logic [0:0] {
        GNT_DAT = 1'b0,
        GNT_CFG = 1'b1
    } grant_e;

    state_e                state_q,      state_d;
    grant_e                last_grant_q, last_grant_d;
    logic                  mul_valid_q,  mul_valid_d;
    logic [TYPE_WIDTH-1:0] mul_type_q,   mul_type_d;
    logic [SEQ_WIDTH-1:0]  mul_seq_q,    mul_seq_d;
    logic [DATA_WIDTH-1:0] mul_data_q,   mul_data_d;
    logic                  cfg_err_q,    cfg_err_d;

    logic gnt_dat_s;
    logic gnt_cfg_s;
    logic dat_acc_s;
    logic cfg_acc_s;
    logic cfg_illegal_s;

    // Grant selection: locked to cfg inside a burst, otherwise round robin on contention.
    always_comb begin
        gnt_dat_s = 1'b0;
        gnt_cfg_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.dat_valid && bus.cfg_valid) begin
                    if (last_grant_q == GNT_DAT) begin
                        gnt_cfg_s = 1'b1;
                    end else begin
                        gnt_dat_s = 1'b1;
                    end
                end else if (bus.dat_valid) begin
                    gnt_dat_s = 1'b1;
                end else if (bus.cfg_valid) begin
                    gnt_cfg_s = 1'b1;
                end else begin
                    gnt_dat_s = 1'b0;
                    gnt_cfg_s = 1'b0;
                end
            end
            ST_CFG_LOCK: begin
                gnt_cfg_s = 1'b1;
            end
            default: begin
                gnt_dat_s = 1'b0;
                gnt_cfg_s = 1'b0;
            end
        endcase
    end

    // Acceptance qualifiers; an accepted DATA-typed cfg beat is consumed but dropped.
    always_comb begin
        dat_acc_s     = bus.dat_valid & gnt_dat_s & ~bus.MUL_halt;
        cfg_acc_s     = bus.cfg_valid & gnt_cfg_s & ~bus.MUL_halt;
        cfg_illegal_s = cfg_acc_s & (bus.cfg_type == TYPE_DATA);
    end

    // Next-state for the output stage, grant history, error flag and burst FSM.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mul_valid_d  = mul_valid_q;
        mul_type_d   = mul_type_q;
        mul_seq_d    = mul_seq_q;
        mul_data_d   = mul_data_q;
        cfg_err_d    = cfg_err_q | cfg_illegal_s;

        if (!bus.MUL_halt) begin
            if (gnt_dat_s) begin
                mul_valid_d = bus.dat_valid;
                mul_type_d  = bus.dat_type;
                mul_seq_d   = bus.dat_seqNum;
                mul_data_d  = bus.dat_data;
            end else if (gnt_cfg_s) begin
                if (cfg_illegal_s) begin
                    mul_valid_d = 1'b0;
                end else begin
                    mul_valid_d = bus.cfg_valid;
                    mul_type_d  = bus.cfg_type;
                    mul_seq_d   = bus.cfg_seqNum;
                    mul_data_d  = bus.cfg_data;
                end
            end else begin
                mul_valid_d = 1'b0;
            end
        end else begin
            mul_valid_d = mul_valid_q;
        end

        if (dat_acc_s) begin
            last_grant_d = GNT_DAT;
        end else if (cfg_acc_s) begin
            last_grant_d = GNT_CFG;
        end else begin
            last_grant_d = last_grant_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (cfg_acc_s && !bus.cfg_last) begin
                    state_d = ST_CFG_LOCK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CFG_LOCK: begin
                if (cfg_acc_s && bus.cfg_last) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CFG_LOCK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any burst in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GNT_DAT;
            mul_valid_q  <= 1'b0;
            mul_type_q   <= {TYPE_WIDTH{1'b0}};
            mul_seq_q    <= {SEQ_WIDTH{1'b0}};
            mul_data_q   <= {DATA_WIDTH{1'b0}};
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mul_valid_q  <= mul_valid_d;
            mul_type_q   <= mul_type_d;
            mul_seq_q    <= mul_seq_d;
            mul_data_q   <= mul_data_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    // Halts mirror the multiplier's combinational halt so requesters stall in the same cycle.
    assign bus.dat_halt   = bus.MUL_halt | ~gnt_dat_s;
    assign bus.cfg_halt   = bus.MUL_halt | ~gnt_cfg_s;
    assign bus.MUL_valid  = mul_valid_q;
    assign bus.MUL_type   = mul_type_q;
    assign bus.MUL_seqNum = mul_seq_q;
    assign bus.MUL_data   = mul_data_q;
    assign bus.cfg_busy   = (state_q == ST_CFG_LOCK);
    assign bus.cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_mul_input_arbiter.sv
// Self-checking bench: directed vector table, hand sequences for reset/throughput,
// then randomized traffic against a behavioural reference model.
module tb_mul_input_arbiter;
    logic clk;
    logic rst;

    int total;
    int bad;

    mul_input_arbiter_if #(.NETWORK_SIZE(256), .PAYLOAD_WIDTH(32), .TYPE_WIDTH(3)) bus ();

    mul_input_arbiter #(.NETWORK_SIZE(256), .PAYLOAD_WIDTH(32), .TYPE_WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [2:0]  dt;
        logic [4:0]  ds;
        logic [39:0] dd;
        logic        cv;
        logic [2:0]  ct;
        logic [4:0]  cs;
        logic [39:0] cd;
        logic        cl;
        logic        mh;
        logic        e_dh;
        logic        e_ch;
        logic        e_v;
        logic [2:0]  e_t;
        logic [4:0]  e_s;
        logic [39:0] e_d;
        logic        e_busy;
        logic        e_err;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(
        input logic dv, input logic [2:0] dt, input logic [4:0] ds, input logic [39:0] dd,
        input logic cv, input logic [2:0] ct, input logic [4:0] cs, input logic [39:0] cd,
        input logic cl, input logic mh,
        input logic e_dh, input logic e_ch, input logic e_v, input logic [2:0] e_t,
        input logic [4:0] e_s, input logic [39:0] e_d, input logic e_busy, input logic e_err);
        vec_t v;
        v.dv = dv; v.dt = dt; v.ds = ds; v.dd = dd;
        v.cv = cv; v.ct = ct; v.cs = cs; v.cd = cd; v.cl = cl; v.mh = mh;
        v.e_dh = e_dh; v.e_ch = e_ch; v.e_v = e_v; v.e_t = e_t; v.e_s = e_s; v.e_d = e_d;
        v.e_busy = e_busy; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic dv, input logic [2:0] dt, input logic [4:0] ds,
                         input logic [39:0] dd, input logic cv, input logic [2:0] ct,
                         input logic [4:0] cs, input logic [39:0] cd, input logic cl,
                         input logic mh);
        bus.dat_valid = dv; bus.dat_type = dt; bus.dat_seqNum = ds; bus.dat_data = dd;
        bus.cfg_valid = cv; bus.cfg_type = ct; bus.cfg_seqNum = cs; bus.cfg_data = cd;
        bus.cfg_last = cl; bus.MUL_halt = mh;
    endtask

    // Reference model: who owns the multiplier and what it sees next.
    bit          m_locked;
    bit          m_last_cfg;
    logic        m_v;
    logic [2:0]  m_t;
    logic [4:0]  m_s;
    logic [39:0] m_d;
    logic        m_err;

    task automatic model_reset();
        m_locked = 1'b0; m_last_cfg = 1'b0;
        m_v = 1'b0; m_t = 3'd0; m_s = 5'd0; m_d = 40'd0; m_err = 1'b0;
    endtask

    task automatic model_step(output bit e_dh, output bit e_ch);
        int who;
        if (m_locked) who = 2;
        else if (bus.dat_valid && bus.cfg_valid) who = m_last_cfg ? 1 : 2;
        else if (bus.dat_valid) who = 1;
        else if (bus.cfg_valid) who = 2;
        else who = 0;
        e_dh = bus.MUL_halt || (who != 1);
        e_ch = bus.MUL_halt || (who != 2);
        if (!bus.MUL_halt) begin
            if (who == 1) begin
                m_v = bus.dat_valid; m_t = bus.dat_type; m_s = bus.dat_seqNum; m_d = bus.dat_data;
                if (bus.dat_valid) m_last_cfg = 1'b0;
            end else if (who == 2) begin
                if (bus.cfg_valid && bus.cfg_type == 3'b000) begin
                    m_v = 1'b0;
                    m_err = 1'b1;
                end else begin
                    m_v = bus.cfg_valid; m_t = bus.cfg_type; m_s = bus.cfg_seqNum; m_d = bus.cfg_data;
                end
                if (bus.cfg_valid) begin
                    m_last_cfg = 1'b1;
                    m_locked = !bus.cfg_last;
                end
            end else begin
                m_v = 1'b0;
            end
        end
    endtask

    bit          e_dh;
    bit          e_ch;
    bit          dat_pend;
    bit          cfg_pend;
    logic [2:0]  legal_types [5];

    initial begin
        total = 0;
        bad   = 0;
        legal_types[0] = 3'b001; legal_types[1] = 3'b010; legal_types[2] = 3'b100;
        legal_types[3] = 3'b101; legal_types[4] = 3'b110;

        // Round robin, burst lock with gap, halt hold, illegal cfg type.
        tbl[0]  = mk(1'b1,3'd0,5'd1,40'h10,   1'b1,3'd2,5'd2,40'h20,1'b1,1'b0, 1'b1,1'b0,1'b1,3'd2,5'd2,40'h20,1'b0,1'b0);
        tbl[1]  = mk(1'b1,3'd0,5'd1,40'h10,   1'b1,3'd2,5'd3,40'h21,1'b1,1'b0, 1'b0,1'b1,1'b1,3'd0,5'd1,40'h10,1'b0,1'b0);
        tbl[2]  = mk(1'b1,3'd0,5'd4,40'h11,   1'b1,3'd2,5'd3,40'h21,1'b1,1'b0, 1'b1,1'b0,1'b1,3'd2,5'd3,40'h21,1'b0,1'b0);
        tbl[3]  = mk(1'b1,3'd0,5'd4,40'h11,   1'b1,3'd2,5'd5,40'h22,1'b1,1'b0, 1'b0,1'b1,1'b1,3'd0,5'd4,40'h11,1'b0,1'b0);
        tbl[4]  = mk(1'b1,3'd0,5'd6,40'h12,   1'b1,3'd2,5'd0,40'h00_0000_0100,1'b0,1'b0, 1'b1,1'b0,1'b1,3'd2,5'd0,40'h00_0000_0100,1'b1,1'b0);
        tbl[5]  = mk(1'b1,3'd0,5'd6,40'h12,   1'b1,3'd2,5'd1,40'h01_0000_0101,1'b0,1'b0, 1'b1,1'b0,1'b1,3'd2,5'd1,40'h01_0000_0101,1'b1,1'b0);
        tbl[6]  = mk(1'b1,3'd0,5'd6,40'h12,   1'b0,3'd2,5'd1,40'h01_0000_0101,1'b0,1'b0, 1'b1,1'b0,1'b0,3'd0,5'd0,40'h0,1'b1,1'b0);
        tbl[7]  = mk(1'b1,3'd0,5'd6,40'h12,   1'b0,3'd2,5'd1,40'h01_0000_0101,1'b0,1'b0, 1'b1,1'b0,1'b0,3'd0,5'd0,40'h0,1'b1,1'b0);
        tbl[8]  = mk(1'b1,3'd0,5'd6,40'h12,   1'b1,3'd2,5'd2,40'h02_0000_0102,1'b0,1'b0, 1'b1,1'b0,1'b1,3'd2,5'd2,40'h02_0000_0102,1'b1,1'b0);
        tbl[9]  = mk(1'b1,3'd0,5'd6,40'h12,   1'b1,3'd2,5'd3,40'h03_0000_0103,1'b1,1'b0, 1'b1,1'b0,1'b1,3'd2,5'd3,40'h03_0000_0103,1'b0,1'b0);
        tbl[10] = mk(1'b1,3'd0,5'd6,40'h12,   1'b0,3'd2,5'd3,40'h03_0000_0103,1'b1,1'b0, 1'b0,1'b1,1'b1,3'd0,5'd6,40'h12,1'b0,1'b0);
        tbl[11] = mk(1'b0,3'd0,5'd0,40'h0,    1'b0,3'd0,5'd0,40'h0,1'b0,1'b0, 1'b1,1'b1,1'b0,3'd0,5'd0,40'h0,1'b0,1'b0);
        tbl[12] = mk(1'b1,3'd0,5'd7,40'hAB,   1'b0,3'd0,5'd0,40'h0,1'b0,1'b0, 1'b0,1'b1,1'b1,3'd0,5'd7,40'hAB,1'b0,1'b0);
        tbl[13] = mk(1'b1,3'd0,5'd8,40'hCD,   1'b0,3'd0,5'd0,40'h0,1'b0,1'b1, 1'b1,1'b1,1'b1,3'd0,5'd7,40'hAB,1'b0,1'b0);
        tbl[14] = mk(1'b1,3'd0,5'd8,40'hCD,   1'b0,3'd0,5'd0,40'h0,1'b0,1'b1, 1'b1,1'b1,1'b1,3'd0,5'd7,40'hAB,1'b0,1'b0);
        tbl[15] = mk(1'b1,3'd0,5'd8,40'hCD,   1'b0,3'd0,5'd0,40'h0,1'b0,1'b1, 1'b1,1'b1,1'b1,3'd0,5'd7,40'hAB,1'b0,1'b0);
        tbl[16] = mk(1'b1,3'd0,5'd8,40'hCD,   1'b0,3'd0,5'd0,40'h0,1'b0,1'b0, 1'b0,1'b1,1'b1,3'd0,5'd8,40'hCD,1'b0,1'b0);
        tbl[17] = mk(1'b0,3'd0,5'd0,40'h0,    1'b0,3'd0,5'd0,40'h0,1'b0,1'b0, 1'b1,1'b1,1'b0,3'd0,5'd0,40'h0,1'b0,1'b0);
        tbl[18] = mk(1'b0,3'd0,5'd0,40'h0,    1'b1,3'd0,5'd9,40'h55,1'b1,1'b0, 1'b1,1'b0,1'b0,3'd0,5'd0,40'h0,1'b0,1'b1);
        tbl[19] = mk(1'b0,3'd0,5'd0,40'h0,    1'b0,3'd0,5'd0,40'h0,1'b0,1'b0, 1'b1,1'b1,1'b0,3'd0,5'd0,40'h0,1'b0,1'b1);

        rst = 1'b0;
        drive(1'b0,3'd0,5'd0,40'd0, 1'b0,3'd0,5'd0,40'd0,1'b0,1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, bus.MUL_valid}, 64'd0);
        chk("rst_data", {24'd0, bus.MUL_data}, 64'd0);
        chk("rst_busy_err", {62'd0, bus.cfg_busy, bus.cfg_err}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].dv, tbl[i].dt, tbl[i].ds, tbl[i].dd, tbl[i].cv, tbl[i].ct,
                  tbl[i].cs, tbl[i].cd, tbl[i].cl, tbl[i].mh);
            #1;
            chk($sformatf("v%0d_dat_halt", i), {63'd0, bus.dat_halt}, {63'd0, tbl[i].e_dh});
            chk($sformatf("v%0d_cfg_halt", i), {63'd0, bus.cfg_halt}, {63'd0, tbl[i].e_ch});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {63'd0, bus.MUL_valid}, {63'd0, tbl[i].e_v});
            chk($sformatf("v%0d_busy", i), {63'd0, bus.cfg_busy}, {63'd0, tbl[i].e_busy});
            chk($sformatf("v%0d_err", i), {63'd0, bus.cfg_err}, {63'd0, tbl[i].e_err});
            if (tbl[i].e_v) begin
                chk($sformatf("v%0d_fields", i), {16'd0, bus.MUL_type, bus.MUL_seqNum, bus.MUL_data},
                    {16'd0, tbl[i].e_t, tbl[i].e_s, tbl[i].e_d});
            end
        end

        // Back-to-back data packets: no bubbles, sequence preserved.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1,3'd0,5'(i),40'h300 + 40'(i), 1'b0,3'd0,5'd0,40'd0,1'b0,1'b0);
            #1;
            chk($sformatf("b2b%0d_dat_halt", i), {63'd0, bus.dat_halt}, 64'd0);
            @(posedge clk);
            #1;
            chk($sformatf("b2b%0d_out", i), {57'd0, bus.MUL_valid, bus.MUL_seqNum, 1'b0},
                {57'd0, 1'b1, 5'(i), 1'b0});
        end

        // Asynchronous reset in the middle of a burst with a valid output.
        drive(1'b0,3'd0,5'd0,40'd0, 1'b1,3'b100,5'd1,40'h77,1'b0,1'b0);
        @(posedge clk);
        #1;
        chk("pre_rst_valid_busy", {62'd0, bus.MUL_valid, bus.cfg_busy}, 64'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_outs", {15'd0, bus.MUL_valid, bus.MUL_type, bus.MUL_seqNum, bus.MUL_data},
            64'd0);
        chk("async_rst_busy_err", {62'd0, bus.cfg_busy, bus.cfg_err}, 64'd0);
        drive(1'b0,3'd0,5'd0,40'd0, 1'b0,3'd0,5'd0,40'd0,1'b0,1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1,3'd0,5'd5,40'h03_0000_0010, 1'b0,3'd0,5'd0,40'd0,1'b0,1'b0);
        @(posedge clk);
        #1;
        chk("post_rst_dat", {17'd0, bus.MUL_valid, bus.MUL_type, bus.MUL_seqNum, bus.MUL_data},
            {17'd0, 1'b1, 3'd0, 5'd5, 40'h03_0000_0010});
        drive(1'b0,3'd0,5'd0,40'd0, 1'b0,3'd0,5'd0,40'd0,1'b0,1'b0);

        // Randomized traffic against the reference model.
        rst = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        dat_pend = 1'b0;
        cfg_pend = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 2000; c++) begin
            if (!dat_pend) begin
                bus.dat_valid  = ($urandom_range(3) != 0);
                bus.dat_type   = ($urandom_range(3) == 0) ? legal_types[$urandom_range(4)] : 3'b000;
                bus.dat_seqNum = 5'($urandom);
                bus.dat_data   = {8'($urandom), 32'($urandom)};
            end
            if (!cfg_pend) begin
                bus.cfg_valid  = ($urandom_range(2) != 0);
                bus.cfg_type   = ($urandom_range(31) == 0) ? 3'b000 : legal_types[$urandom_range(4)];
                bus.cfg_seqNum = 5'($urandom);
                bus.cfg_data   = {8'($urandom), 32'($urandom)};
                bus.cfg_last   = ($urandom_range(2) == 0);
            end
            bus.MUL_halt = ($urandom_range(3) == 0);
            #1;
            model_step(e_dh, e_ch);
            chk("rnd_dat_halt", {63'd0, bus.dat_halt}, {63'd0, e_dh});
            chk("rnd_cfg_halt", {63'd0, bus.cfg_halt}, {63'd0, e_ch});
            dat_pend = bus.dat_valid && e_dh;
            cfg_pend = bus.cfg_valid && e_ch;
            @(posedge clk);
            #1;
            chk("rnd_valid", {63'd0, bus.MUL_valid}, {63'd0, m_v});
            chk("rnd_busy_err", {62'd0, bus.cfg_busy, bus.cfg_err}, {62'd0, m_locked, m_err});
            if (m_v) begin
                chk("rnd_fields", {16'd0, bus.MUL_type, bus.MUL_seqNum, bus.MUL_data},
                    {16'd0, m_t, m_s, m_d});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_input_arbiter.md
Name: mul_input_arbiter

Overview:
- Shares the multiplier's single packet input (SNC_MUL_* side) between two requesters: the NoC data path (dat_*) and the local configuration loader (cfg_*).
- Round-robin arbitration per packet. The grant is locked to the config requester for the whole of a multi-beat weight/config burst, so no data packet is ever interleaved into a weight load.
- One registered output stage, and full propagation of the multiplier's halt back to both requesters.

Parameters:
- NETWORK_SIZE, 256, number of neurons; sets SOURCE_WIDTH = $clog2(NETWORK_SIZE) and SEQ_WIDTH = $clog2($sqrt(NETWORK_SIZE)*2).
- PAYLOAD_WIDTH, 32, payload bits per packet.
- TYPE_WIDTH, 3, packet type field width. Type codes: DATA=3'b000, CONF_INB=3'b001, CONF_W=3'b010, CONF_AFLUT=3'b100, CONF_AFLB=3'b101, CONF_AFUB=3'b110.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- dat_valid  in  1  data requester has a packet.
- dat_type  in  TYPE_WIDTH  packet type.
- dat_seqNum  in  SEQ_WIDTH  sequence number.
- dat_data  in  PAYLOAD_WIDTH+SOURCE_WIDTH  {source, payload}.
- dat_halt  out  1  data requester must hold its fields.
- cfg_valid  in  1  config requester has a beat.
- cfg_type  in  TYPE_WIDTH  beat type.
- cfg_seqNum  in  SEQ_WIDTH  sequence number.
- cfg_data  in  PAYLOAD_WIDTH+SOURCE_WIDTH  {address/source, payload}.
- cfg_last  in  1  final beat of a config burst.
- cfg_halt  out  1  config requester must hold its fields.
- MUL_halt  in  1  halt from the multiplier.
- MUL_valid  out  1  registered packet valid to the multiplier.
- MUL_type  out  TYPE_WIDTH  registered type.
- MUL_seqNum  out  SEQ_WIDTH  registered sequence number.
- MUL_data  out  PAYLOAD_WIDTH+SOURCE_WIDTH  registered data.
- cfg_busy  out  1  high while in CFG_LOCK.
- cfg_err  out  1  sticky; a DATA-type beat was received on the cfg port.

Behaviour:
- Reset (rst=0, asynchronous) clears:
  - MUL_valid, MUL_type, MUL_seqNum, MUL_data, cfg_err → 0.
  - state → IDLE; last_grant → DAT.
  - Reset mid-burst abandons the burst: state IDLE, MUL_valid=0. No partial recovery.
- A beat is accepted when the requester's valid=1 and its halt=0 in the same cycle. Requesters hold their fields stable while halt=1.
- Halt equations (combinational, as in the multiplier):
  - dat_halt = MUL_halt | ~gnt_dat.
  - cfg_halt = MUL_halt | ~gnt_cfg.
- Output register:
  - MUL_halt=1: every MUL_* output holds its value; no beat is accepted; state, last_grant and cfg_err are unchanged.
  - MUL_halt=0: on every clock, the MUL_* outputs load the granted requester's fields, with MUL_valid = that requester's valid. With no grant, MUL_valid loads 0 and the other MUL_* outputs hold.
  - Latency: 1 cycle from acceptance to MUL_valid.
- State machine (2 states, IDLE and CFG_LOCK):
  - IDLE, only dat_valid: gnt_dat.
  - IDLE, only cfg_valid: gnt_cfg.
  - IDLE, both valid: grant the requester that is not last_grant (round robin).
  - IDLE, neither valid: no grant; state holds.
  - IDLE, accepted cfg beat with cfg_last=0: go to CFG_LOCK.
  - IDLE, accepted cfg beat with cfg_last=1: single-beat config; stay in IDLE.
  - CFG_LOCK: gnt_cfg=1 and gnt_dat=0 unconditionally, even if cfg_valid=0 (idle gaps inside a burst are allowed).
  - CFG_LOCK, accepted beat with cfg_last=1: go to IDLE.
  - last_grant updates only on an accepted beat.
- cfg_busy = (state == CFG_LOCK).
- Illegal config beat: a cfg beat with cfg_type==DATA is accepted (cfg_halt follows the normal rule) but not forwarded.
  - MUL_valid loads 0 that cycle.
  - cfg_err goes to 1 and stays there until reset.
  - cfg_last on that beat still applies to the state transitions.
- The block passes all other type codes through unchanged. It does not inspect payload or source fields.

Test Plan:
- Reset: assert rst=0 mid-operation, with MUL_valid=1 and state CFG_LOCK → all outputs 0 asynchronously, before the next edge. After release, a dat beat (type 000, seq 5, data 0x03_0000_0010) appears on MUL_* one cycle after acceptance.
- Round robin: dat_valid and cfg_valid held high with single-beat configs (cfg_last=1), MUL_halt=0 → grants alternate cfg, dat, cfg, dat. The first grant goes to cfg because last_grant=DAT after reset. MUL_type sequence is 010, 000, 010, 000.
- Burst lock: 4-beat CONF_W burst (addresses 0..3, cfg_last on beat 3) with dat_valid=1 throughout, plus a 2-cycle cfg_valid gap after beat 1 → dat_halt=1 for the whole burst, including the gap; cfg_busy=1. The dat packet is forwarded in the cycle after beat 3 is accepted.
- Halt: MUL_halt=1 for 3 cycles with MUL_valid=1 and data 0xAB → MUL_* hold 0xAB; dat_halt=cfg_halt=1; nothing is accepted. On release, the next granted beat appears after 1 cycle.
- Illegal type: cfg beat with type 000 and cfg_last=1 → MUL_valid=0 on the next cycle, cfg_err=1 and sticky; state stays IDLE.
- Back-to-back throughput: dat_valid=1 for 10 cycles with no cfg traffic → 10 consecutive MUL_valid=1 cycles with seqNum 0..9 in order, with no bubbles.
